// File: rtl/audio_sd_pkg.sv
// Shared definitions for the SD audio record/playback controllers.
// Both controllers use these constants so they agree on one recording area.
package audio_sd_pkg;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StWait  = 3'd1,
      StStart = 3'd2,
      StBusy  = 3'd3,
      StDone  = 3'd4
   } rec_state_e;

   localparam int unsigned SEC_WORDS      = 256;
   localparam int unsigned DEF_START_ADDR = 8448;
   localparam int unsigned DEF_REC_SEC    = 104422;

endpackage

// File: rtl/audio_sd_rec_ctrl.sv
// Record-path controller: drains 16-bit ADC samples from a show-ahead FIFO and
// writes them to consecutive SD sectors, one 256-word sector per write.
module audio_sd_rec_ctrl
   import audio_sd_pkg::*;
#(
   parameter int unsigned START_ADDR = DEF_START_ADDR,
   parameter int unsigned REC_SEC    = DEF_REC_SEC
) (
   input  logic        sd_clk,
   input  logic        rst,
   input  logic        sd_init_done,
   input  logic        rec_en,
   input  logic [9:0]  fifo_usedw,
   input  logic [15:0] fifo_q,
   output logic        fifo_rd_en,
   input  logic        wr_busy,
   input  logic        wr_req,
   output logic        wr_start_en,
   output logic [31:0] wr_sec_addr,
   output logic [15:0] wr_data,
   output logic        rec_done,
   output logic [16:0] rec_sec_cnt,
   output logic        word_err
);

   localparam logic [8:0]  SecWords  = 9'(SEC_WORDS);
   localparam logic [9:0]  UsedwThr  = 10'(SEC_WORDS);
   localparam logic [16:0] RecSec    = 17'(REC_SEC);
   localparam logic [31:0] StartAddr = 32'(START_ADDR);

   rec_state_e  state_q, state_d;
   logic        wr_start_en_q, wr_start_en_d;
   logic [31:0] wr_sec_addr_q, wr_sec_addr_d;
   logic        rec_done_q, rec_done_d;
   logic [16:0] rec_sec_cnt_q, rec_sec_cnt_d;
   logic [8:0]  word_cnt_q, word_cnt_d;
   logic        word_err_q, word_err_d;
   logic        busy_d0_q, busy_d1_q;
   logic        neg_busy;
   logic [16:0] sec_cnt_inc;

   assign neg_busy    = busy_d1_q & ~busy_d0_q;
   assign sec_cnt_inc = rec_sec_cnt_q + 17'd1;

   // Playback expects little-endian byte order on the card.
   assign wr_data    = {fifo_q[7:0], fifo_q[15:8]};
   assign fifo_rd_en = wr_req & (state_q == StBusy) & (word_cnt_q < SecWords);

   assign wr_start_en = wr_start_en_q;
   assign wr_sec_addr = wr_sec_addr_q;
   assign rec_done    = rec_done_q;
   assign rec_sec_cnt = rec_sec_cnt_q;
   assign word_err    = word_err_q;

   always_comb begin
      state_d       = state_q;
      wr_start_en_d = 1'b0;
      wr_sec_addr_d = wr_sec_addr_q;
      rec_sec_cnt_d = rec_sec_cnt_q;
      word_err_d    = word_err_q;
      word_cnt_d    = fifo_rd_en ? word_cnt_q + 9'd1 : word_cnt_q;

      unique case (state_q)
         StIdle: begin
            if (sd_init_done && rec_en) begin
               rec_sec_cnt_d = '0;
               word_err_d    = 1'b0;
               state_d       = StWait;
            end
         end
         StWait: begin
            if (!rec_en) begin
               state_d = StDone;
            end else if (fifo_usedw >= UsedwThr) begin
               // Pulse and address are registered so both are valid in StStart.
               wr_start_en_d = 1'b1;
               wr_sec_addr_d = StartAddr + {15'd0, rec_sec_cnt_q};
               word_cnt_d    = '0;
               state_d       = StStart;
            end
         end
         StStart: begin
            state_d = StBusy;
         end
         StBusy: begin
            if (neg_busy) begin
               if (word_cnt_q != SecWords) begin
                  word_err_d = 1'b1;
               end
               rec_sec_cnt_d = sec_cnt_inc;
               state_d       = (sec_cnt_inc == RecSec || !rec_en) ? StDone : StWait;
            end
         end
         StDone: begin
            if (!rec_en) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      rec_done_d = (state_d == StDone);
   end

   always_ff @(posedge sd_clk) begin
      if (rst) begin
         state_q       <= StIdle;
         wr_start_en_q <= 1'b0;
         wr_sec_addr_q <= '0;
         rec_done_q    <= 1'b0;
         rec_sec_cnt_q <= '0;
         word_cnt_q    <= '0;
         word_err_q    <= 1'b0;
         busy_d0_q     <= 1'b0;
         busy_d1_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         wr_start_en_q <= wr_start_en_d;
         wr_sec_addr_q <= wr_sec_addr_d;
         rec_done_q    <= rec_done_d;
         rec_sec_cnt_q <= rec_sec_cnt_d;
         word_cnt_q    <= word_cnt_d;
         word_err_q    <= word_err_d;
         busy_d0_q     <= wr_busy;
         busy_d1_q     <= busy_d0_q;
      end
   end

endmodule

// File: tb/tb_audio_sd_rec_ctrl.sv
// Scoreboard bench for audio_sd_rec_ctrl: a FIFO model, an SD-writer model and
// a negedge monitor that checks every start pulse and every popped word.
module tb_audio_sd_rec_ctrl;

   logic        sd_clk = 1'b0;
   logic        rst = 1'b1;
   logic        sd_init_done = 1'b0;
   logic        rec_en = 1'b0;
   logic [9:0]  fifo_usedw = '0;
   logic [15:0] fifo_q;
   logic        fifo_rd_en;
   logic        wr_busy = 1'b0;
   logic        wr_req = 1'b0;
   logic        wr_start_en;
   logic [31:0] wr_sec_addr;
   logic [15:0] wr_data;
   logic        rec_done;
   logic [16:0] rec_sec_cnt;
   logic        word_err;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [15:0] fifo_idx = '0;
   int          exp_idx = 0;
   logic [31:0] exp_addr[$];
   logic [15:0] exp_data[$];

   audio_sd_rec_ctrl #(
      .START_ADDR(8448),
      .REC_SEC   (4)
   ) dut (
      .sd_clk      (sd_clk),
      .rst         (rst),
      .sd_init_done(sd_init_done),
      .rec_en      (rec_en),
      .fifo_usedw  (fifo_usedw),
      .fifo_q      (fifo_q),
      .fifo_rd_en  (fifo_rd_en),
      .wr_busy     (wr_busy),
      .wr_req      (wr_req),
      .wr_start_en (wr_start_en),
      .wr_sec_addr (wr_sec_addr),
      .wr_data     (wr_data),
      .rec_done    (rec_done),
      .rec_sec_cnt (rec_sec_cnt),
      .word_err    (word_err)
   );

   always #5 sd_clk = ~sd_clk;

   // Show-ahead FIFO model: word n holds 0x1234 + n.
   assign fifo_q = 16'h1234 + fifo_idx;
   always @(posedge sd_clk) if (fifo_rd_en === 1'b1) fifo_idx <= fifo_idx + 16'd1;

   function automatic logic [15:0] swap16(input logic [15:0] w);
      return {w[7:0], w[15:8]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge sd_clk) begin
      if (fifo_rd_en === 1'b1) begin
         if (exp_data.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL extra_pop: got pop of 0x%0h, expected no pop at %0t", wr_data, $time);
         end else begin
            check("wr_data", {16'd0, wr_data}, {16'd0, exp_data.pop_front()});
         end
      end
      if (wr_start_en === 1'b1) begin
         if (exp_addr.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL extra_start: got start at 0x%0h, expected none at %0t",
                     wr_sec_addr, $time);
         end else begin
            check("wr_sec_addr", wr_sec_addr, exp_addr.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge sd_clk);
      #1;
   endtask

   task automatic wait_start();
      int k = 0;
      while (wr_start_en !== 1'b1 && k < 64) begin
         tick();
         k++;
      end
      if (k == 64) check("start_timeout", 32'd0, 32'd1);
   endtask

   // Called in the start-pulse cycle; models an SD writer issuing n_req requests.
   task automatic sector_body(input int n_req, input bit drop_en);
      int np = (n_req > 256) ? 256 : n_req;
      for (int j = 0; j < np; j++) exp_data.push_back(swap16(16'h1234 + 16'(exp_idx + j)));
      exp_idx += np;
      wr_busy = 1'b1;
      tick();
      if (drop_en) rec_en = 1'b0;
      for (int i = 0; i < n_req; i++) begin
         wr_req = 1'b1;
         tick();
      end
      wr_req  = 1'b0;
      wr_busy = 1'b0;
      tick();
      tick();
      check("pops_missing", exp_data.size(), 32'd0);
   endtask

   initial begin
      // Reset and idle behaviour
      repeat (3) tick();
      rst        = 1'b0;
      fifo_usedw = 10'd300;
      rec_en     = 1'b1;
      repeat (4) tick();
      rec_en       = 1'b0;
      sd_init_done = 1'b1;
      wr_req       = 1'b1;
      repeat (3) tick();
      check("idle_rd_en", fifo_rd_en, 1'b0);
      check("idle_start", wr_start_en, 1'b0);
      check("idle_addr", wr_sec_addr, 32'd0);
      check("idle_done", rec_done, 1'b0);
      check("idle_cnt", rec_sec_cnt, 17'd0);
      check("idle_err", word_err, 1'b0);
      wr_req = 1'b0;

      // Session A: overrequest, threshold, short sector, limit of 4 sectors
      exp_addr.push_back(32'd8448);
      rec_en = 1'b1;
      wait_start();
      fifo_usedw = 10'd255;
      sector_body(258, 1'b0);
      check("s0_cnt", rec_sec_cnt, 17'd1);
      check("s0_err", word_err, 1'b0);
      repeat (10) tick();
      exp_addr.push_back(32'd8449);
      fifo_usedw = 10'd256;
      tick();
      check("start_latency", wr_start_en, 1'b1);
      fifo_usedw = 10'd300;
      sector_body(250, 1'b0);
      check("s1_err", word_err, 1'b1);
      check("s1_cnt", rec_sec_cnt, 17'd2);
      exp_addr.push_back(32'd8450);
      wait_start();
      sector_body(256, 1'b0);
      check("s2_err_sticky", word_err, 1'b1);
      check("s2_cnt", rec_sec_cnt, 17'd3);
      exp_addr.push_back(32'd8451);
      wait_start();
      sector_body(256, 1'b0);
      check("limit_cnt", rec_sec_cnt, 17'd4);
      check("limit_done", rec_done, 1'b1);
      repeat (5) tick();
      check("limit_done_hold", rec_done, 1'b1);
      rec_en = 1'b0;
      tick();
      check("limit_done_clr", rec_done, 1'b0);
      check("limit_cnt_hold", rec_sec_cnt, 17'd4);

      // Session B: stop during the third sector
      exp_addr.push_back(32'd8448);
      exp_addr.push_back(32'd8449);
      exp_addr.push_back(32'd8450);
      rec_en = 1'b1;
      tick();
      check("b_cnt_clr", rec_sec_cnt, 17'd0);
      check("b_err_clr", word_err, 1'b0);
      wait_start();
      sector_body(256, 1'b0);
      wait_start();
      sector_body(256, 1'b0);
      wait_start();
      sector_body(256, 1'b1);
      check("stop_cnt", rec_sec_cnt, 17'd3);
      check("stop_done", rec_done, 1'b1);
      check("stop_err", word_err, 1'b0);
      tick();
      check("stop_idle_done", rec_done, 1'b0);
      check("stop_idle_cnt", rec_sec_cnt, 17'd3);

      // Session C: reset in the middle of a sector write
      exp_addr.push_back(32'd8448);
      exp_addr.push_back(32'd8449);
      rec_en = 1'b1;
      wait_start();
      sector_body(256, 1'b0);
      wait_start();
      for (int j = 0; j < 10; j++) exp_data.push_back(swap16(16'h1234 + 16'(exp_idx + j)));
      exp_idx += 10;
      wr_busy = 1'b1;
      tick();
      for (int i = 0; i < 10; i++) begin
         wr_req = 1'b1;
         tick();
      end
      wr_req = 1'b0;
      rst    = 1'b1;
      tick();
      rst     = 1'b0;
      rec_en  = 1'b0;
      wr_busy = 1'b0;
      wr_req  = 1'b1;
      #1;
      check("rst_rd_en", fifo_rd_en, 1'b0);
      check("rst_addr", wr_sec_addr, 32'd0);
      check("rst_cnt", rec_sec_cnt, 17'd0);
      check("rst_done", rec_done, 1'b0);
      check("rst_start", wr_start_en, 1'b0);
      check("rst_pops", exp_data.size(), 32'd0);
      repeat (3) tick();
      wr_req = 1'b0;
      check("rst_no_start", exp_addr.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/audio_sd_rec_ctrl.md
Name: audio_sd_rec_ctrl

Overview:
Record-path counterpart of the SD-to-WM8978 playback controller. It drains 16-bit ADC samples from a show-ahead dual-clock FIFO (filled on the aud_bclk side) and writes them to consecutive SD sectors through the SD write controller, one 512-byte sector (256 words) per write. It sits between the record FIFO and sd_write, entirely in the sd_clk domain.

Parameters:
START_ADDR, 8448, first SD sector of the recording area
REC_SEC, 104422, maximum sectors recorded per session (17-bit)
SEC_WORDS, 256, 16-bit words per sector

Ports:
sd_clk  in  1  SD controller clock; sole clock
rst  in  1  synchronous active-high reset
sd_init_done  in  1  SD card initialisation complete
rec_en  in  1  level: 1 = record, 0 = stop after the current sector
fifo_usedw  in  10  words currently held in the record FIFO
fifo_q  in  16  FIFO head word (show-ahead, valid while usedw > 0)
fifo_rd_en  out  1  FIFO pop, combinational
wr_busy  in  1  SD write controller busy
wr_req  in  1  SD write controller requests the next word, same cycle
wr_start_en  out  1  one-cycle pulse starting a sector write
wr_sec_addr  out  32  sector address, stable from the pulse until busy falls
wr_data  out  16  byte-swapped FIFO word, combinational
rec_done  out  1  session finished
rec_sec_cnt  out  17  sectors written this session
word_err  out  1  sticky: a sector closed with word count != SEC_WORDS

Behaviour:
- Reset is synchronous and active-high. All registers clear: state=IDLE, wr_start_en=0, wr_sec_addr=0, rec_done=0, rec_sec_cnt=0, word_cnt=0, word_err=0, busy_d0/busy_d1=0.
- Reset mid-write clears state immediately. The block does not wait for wr_busy.
- wr_busy is registered twice (busy_d0, busy_d1). neg_busy = busy_d1 & ~busy_d0.
- wr_data = {fifo_q[7:0], fifo_q[15:8]}. This is the same little-endian byte order the playback path expects.
- fifo_rd_en = wr_req & (state==BUSY) & (word_cnt < SEC_WORDS). It never pops outside BUSY, and never pops more than 256 words per sector.
- word_cnt is 9 bits. It increments on each fifo_rd_en and clears on entry to START.
- State machine:
  - IDLE: if sd_init_done & rec_en, clear rec_sec_cnt and word_err, then go to WAIT.
  - WAIT:
    - if !rec_en, go to DONE;
    - else if fifo_usedw >= SEC_WORDS, go to START.
  - START (one cycle):
    - wr_start_en=1;
    - wr_sec_addr <= START_ADDR + rec_sec_cnt (32-bit add, zero-extended);
    - word_cnt <= 0;
    - go to BUSY.
  - BUSY: on neg_busy:
    - set word_err if word_cnt != SEC_WORDS;
    - rec_sec_cnt++;
    - if rec_sec_cnt+1 == REC_SEC or !rec_en, go to DONE; else go to WAIT.
  - DONE: rec_done=1. When rec_en=0, clear rec_done and go to IDLE. rec_sec_cnt is held until the next session start.
- Latency: from the WAIT cycle that sees usedw >= 256 to wr_start_en is 1 cycle.
- Because busy is synchronised, busy must go low at least 2 cycles after START before neg_busy can be seen. Busy that never rises leaves the block in BUSY; there is no timeout.
- rec_en dropping during BUSY does not abort the sector. The sector completes, then the block goes to DONE.
- sd_init_done is checked only in IDLE.
- Boundary at REC_SEC: the last sector written is START_ADDR+REC_SEC-1, and rec_sec_cnt saturates at REC_SEC.

Decomposition:
- Shared package (audio_sd_pkg) holds:
  - the state encoding: IDLE=0, WAIT=1, START=2, BUSY=3, DONE=4 (3 bits);
  - SEC_WORDS;
  - the default START_ADDR and REC_SEC, shared with the playback controller so both use one recording area.
- No sub-module is needed. The busy edge detector is small enough to stay inline.

Test Plan:
1. Reset/idle: rst=1 for 3 cycles, then sd_init_done=1 with rec_en=0 → state stays IDLE; all outputs 0; fifo_rd_en=0 even with wr_req=1.
2. Single sector: rec_en=1, usedw=300, FIFO words 0x1234… → wr_start_en pulses once with wr_sec_addr=8448. Under 256 wr_req pulses: first wr_data=0x3412, exactly 256 pops. After busy falls: rec_sec_cnt=1, next address 8449.
3. Threshold: usedw=255 held → no wr_start_en. usedw becomes 256 → pulse 1 cycle after WAIT sees it.
4. Overrequest: the SD model issues 258 wr_req → only 256 pops; no word_err. Model issues 250 then drops busy → word_err=1, and it stays 1 through later sectors.
5. Stop mid-sector: deassert rec_en during BUSY of sector 3 → sector completes, rec_sec_cnt=3, rec_done=1; then rec_en stays 0 → IDLE next cycle.
6. Limit and reset: REC_SEC=4 override → exactly 4 sectors (8448..8451) then rec_done. In a separate run, assert rst during BUSY → IDLE next cycle with all outputs cleared.
